usb3_ep_out_arb: RTL and testbench
==================================

Name: usb3_ep_out_arb

Overview:
Arbiter that shares the protocol layer's single device-to-host read port between NUM_EP endpoint output buffers (ep0 plus bulk/interrupt INs). It picks an endpoint with pending data, muxes its address, data and length to the protocol layer, and sequences that endpoint's arm/arm_ack release handshake once the packet is sent. It sits between the protocol layer and the per-endpoint buffer modules.

Parameters:
NUM_EP, 3, number of endpoint output buffers (2..8); index 0 is ep0.
ACK_TIMEOUT, 255, local_clk cycles allowed for arm_ack to rise, and separately for it to fall, before the arbiter gives up.

Ports:
local_clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
ep_hasdata  in  NUM_EP  per-endpoint buf_out_hasdata.
ep_len  in  NUM_EP*11  per-endpoint buf_out_len; slice i is bits [11i+10:11i].
ep_q  in  NUM_EP*32  per-endpoint buf_out_q.
ep_addr  out  9  read address broadcast to all endpoints; equals prot_addr.
ep_arm  out  NUM_EP  per-endpoint buf_out_arm level.
ep_arm_ack  in  NUM_EP  per-endpoint buf_out_arm_ack.
prot_addr  in  9  protocol layer read address.
prot_q  out  32  muxed data of the granted endpoint; 0 when no grant.
prot_len  out  11  muxed length of the granted endpoint; 0 when no grant.
prot_valid  out  1  a grant is active and the packet is available.
prot_ep  out  3  index of the granted endpoint.
prot_done  in  1  one-cycle pulse: packet accepted by host; release the buffer.
prot_abort  in  1  one-cycle pulse: packet not sent (retry later); keep the buffer.
err_timeout  out  1  sticky; set on any arm_ack timeout; cleared only by reset.

Behaviour:
- Reset values: ep_arm=0, prot_valid=0, prot_ep=0, err_timeout=0, rr pointer=0, state=IDLE, timer=0.
- Data path: ep_addr=prot_addr, combinational. prot_q and prot_len are combinational muxes on the registered prot_ep, gated by prot_valid. The endpoint's one-cycle ROM/RAM read latency is the protocol layer's concern.
- State machine:
  - IDLE: if any ep_hasdata, pick the winner (see arbitration), register prot_ep, go to GRANT. prot_valid rises in the next cycle, which is one cycle of grant latency.
  - GRANT: prot_valid=1.
    - prot_done: drop prot_valid, set ep_arm[prot_ep]=1, clear timer, go to ARM.
    - prot_abort: drop prot_valid, advance the rr pointer past prot_ep, go to IDLE without arming.
    - Both pulses in the same cycle: prot_done wins.
    - ep_hasdata[prot_ep] falling while in GRANT is ignored; the grant is held.
  - ARM: hold ep_arm high, because the endpoint samples arm through a 2-flop synchronizer and edge detect.
    - When ep_arm_ack[prot_ep]=1: drop ep_arm, clear timer, go to ACKWAIT.
    - When timer==ACK_TIMEOUT: drop ep_arm, set err_timeout, go to RELEASE.
  - ACKWAIT: wait for ep_arm_ack[prot_ep]=0 (the ack lasts about 4 cycles), then go to RELEASE. On timeout, set err_timeout and go to RELEASE.
  - RELEASE: one cycle that lets hasdata settle after the endpoint's swap. Advance rr to (prot_ep+1) mod NUM_EP, then go to IDLE.
- Arbitration: round-robin starting at the rr pointer; the first set ep_hasdata bit scanning upward with wrap-around wins. NUM_EP not a power of two: the pointer wraps from NUM_EP-1 to 0 explicitly.
- prot_done or prot_abort outside GRANT: ignored.
- Timer: 8-bit saturating, resized to clog2(ACK_TIMEOUT+1).
- Reset mid-operation: all outputs return to reset values the next cycle. An asserted ep_arm drops with no ack wait.
- Only one ep_arm bit is ever high at a time.

Optional Feature:
USB3_EP_ARB_EP0_PRIO_EN
- Defined: if ep_hasdata[0] is set in IDLE, endpoint 0 wins regardless of the rr pointer. Granting endpoint 0 does not advance the pointer, so bulk fairness among 1..NUM_EP-1 is preserved. This gives control-transfer responses bounded latency.
- Undefined: pure round-robin over all endpoints.

Decomposition:
- Shared package/include (usb3_const.v style): state encodings ST_ARB_IDLE/GRANT/ARM/ACKWAIT/RELEASE and the endpoint-index width constant EP_IDX_W=3.
- One sub-module: usb3_rr_pick. It is combinational: request vector plus pointer in, one-hot grant and index out. It is parameterized by NUM_EP and reusable for an IN-direction arbiter.

Test Plan:
- Single request: ep_hasdata=3'b010 → prot_valid=1 and prot_ep=1 two cycles later; prot_len=ep_len slice 1 (e.g. 11'd512); prot_q tracks ep_q slice 1 for prot_addr=0..3.
- Full handshake: prot_done, endpoint model acks after sync (ack high 4 cycles, hasdata dropped on swap) → ep_arm[1] high until ack, prot_valid=0 after release, rr=2, err_timeout=0.
- Fairness: all three hasdata held high, done each time → grant order 0,1,2,0,1,2. With USB3_EP_ARB_EP0_PRIO_EN and ep0 re-requesting each time → 0,1,0,2,0,1.
- Abort: grant ep2, prot_abort → ep_arm stays 0, hasdata[2] still 1, next grant goes to ep0 if it is requesting, else ep2 again.
- Timeout: ack never asserted → ep_arm drops after 256 cycles in ARM, err_timeout=1 sticky, arbiter back in IDLE and granting again.
- Reset mid-ARM: reset pulse while ep_arm[0]=1 → ep_arm=0, prot_valid=0 next cycle; rr=0 and err_timeout=0 after reset.

Source files
------------

// File: rtl/usb3_ep_out_arb_pkg.sv
// Shared constants, state encoding and payload types for the endpoint OUT-buffer arbiter.
package usb3_ep_out_arb_pkg;

  localparam int unsigned EP_IDX_W = 3;
  localparam int unsigned Q_W      = 32;
  localparam int unsigned LEN_W    = 11;
  localparam int unsigned ADDR_W   = 9;

  typedef enum logic [2:0] {
    ST_ARB_IDLE    = 3'd0,
    ST_ARB_GRANT   = 3'd1,
    ST_ARB_ARM     = 3'd2,
    ST_ARB_ACKWAIT = 3'd3,
    ST_ARB_RELEASE = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [Q_W-1:0]   q;
  } ep_rd_t;

  // Next endpoint index with explicit wrap, valid for non-power-of-two counts.
  function automatic logic [EP_IDX_W-1:0] ep_wrap_inc(input logic [EP_IDX_W-1:0] idx,
                                                       input int unsigned num_ep);
    if (32'(idx) + 32'd1 >= num_ep) return '0;
    return EP_IDX_W'(32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/usb3_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module usb3_rr_pick
  import usb3_ep_out_arb_pkg::*;
#(
  parameter int unsigned NUM_EP = 3
) (
  input  logic [NUM_EP-1:0]   req,
  input  logic [EP_IDX_W-1:0] ptr,
  output logic [NUM_EP-1:0]   gnt_c,
  output logic [EP_IDX_W-1:0] idx_c,
  output logic                any_c
);

  int unsigned cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_EP; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_EP) cand = cand - NUM_EP;
      // constant-index compare keeps the request select free of width truncation
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        if (!any_c && cand == i && req[i]) begin
          gnt_c[i] = 1'b1;
          idx_c    = EP_IDX_W'(i);
          any_c    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb3_ep_out_arb.sv
// Shares the protocol layer's device-to-host read port between NUM_EP endpoint OUT buffers.
// Optional macro USB3_EP_ARB_EP0_PRIO_EN: ep0 wins in IDLE whenever it has data.
module usb3_ep_out_arb
  import usb3_ep_out_arb_pkg::*;
#(
  parameter int unsigned NUM_EP      = 3,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                      local_clk,
  input  logic                      reset,
  input  logic [NUM_EP-1:0]         ep_hasdata,
  input  logic [NUM_EP*LEN_W-1:0]   ep_len,
  input  logic [NUM_EP*Q_W-1:0]     ep_q,
  output logic [ADDR_W-1:0]         ep_addr,
  output logic [NUM_EP-1:0]         ep_arm,
  input  logic [NUM_EP-1:0]         ep_arm_ack,
  input  logic [ADDR_W-1:0]         prot_addr,
  output logic [Q_W-1:0]            prot_q,
  output logic [LEN_W-1:0]          prot_len,
  output logic                      prot_valid,
  output logic [EP_IDX_W-1:0]       prot_ep,
  input  logic                      prot_done,
  input  logic                      prot_abort,
  output logic                      err_timeout
);

  localparam int unsigned     TMR_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT);

  arb_state_e          state_q, state_d;
  logic [EP_IDX_W-1:0] prot_ep_q, prot_ep_d;
  logic [NUM_EP-1:0]   gnt_q, gnt_d;
  logic                prot_valid_q, prot_valid_d;
  logic [NUM_EP-1:0]   ep_arm_q, ep_arm_d;
  logic                err_q, err_d;
  logic [EP_IDX_W-1:0] rr_q, rr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [NUM_EP-1:0]   rr_gnt_c;
  logic [EP_IDX_W-1:0] rr_idx_c;
  logic                rr_any_c;
  logic [NUM_EP-1:0]   win_oh_c;
  logic [EP_IDX_W-1:0] win_idx_c;
  logic [EP_IDX_W-1:0] rr_next_c;
  logic                ack_sel_c;
  ep_rd_t              sel_rd_c;

  usb3_rr_pick #(.NUM_EP(NUM_EP)) u_pick (
    .req   (ep_hasdata),
    .ptr   (rr_q),
    .gnt_c (rr_gnt_c),
    .idx_c (rr_idx_c),
    .any_c (rr_any_c)
  );

`ifdef USB3_EP_ARB_EP0_PRIO_EN
  // ep0 bypasses the pointer and never moves it, so bulk fairness among 1.. is kept
  assign win_oh_c  = ep_hasdata[0] ? NUM_EP'(1) : rr_gnt_c;
  assign win_idx_c = ep_hasdata[0] ? '0 : rr_idx_c;
  assign rr_next_c = (prot_ep_q == '0) ? rr_q : ep_wrap_inc(prot_ep_q, NUM_EP);
`else
  assign win_oh_c  = rr_gnt_c;
  assign win_idx_c = rr_idx_c;
  assign rr_next_c = ep_wrap_inc(prot_ep_q, NUM_EP);
`endif

  assign ack_sel_c = |(ep_arm_ack & gnt_q);

  // Read-data mux on the registered grant, zeroed when nothing is granted
  always_comb begin
    sel_rd_c = '0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (prot_valid_q && gnt_q[i]) begin
        sel_rd_c.q   = ep_q[i*Q_W +: Q_W];
        sel_rd_c.len = ep_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prot_ep_d    = prot_ep_q;
    gnt_d        = gnt_q;
    prot_valid_d = 1'b0;
    ep_arm_d     = ep_arm_q;
    err_d        = err_q;
    rr_d         = rr_q;
    timer_d      = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
    case (state_q)
      ST_ARB_IDLE: begin
        if (rr_any_c) begin
          prot_ep_d = win_idx_c;
          gnt_d     = win_oh_c;
          state_d   = ST_ARB_GRANT;
        end
      end
      ST_ARB_GRANT: begin
        prot_valid_d = 1'b1;
        if (prot_done) begin
          prot_valid_d = 1'b0;
          ep_arm_d     = gnt_q;
          timer_d      = '0;
          state_d      = ST_ARB_ARM;
        end else if (prot_abort) begin
          prot_valid_d = 1'b0;
          rr_d         = rr_next_c;
          state_d      = ST_ARB_IDLE;
        end
      end
      ST_ARB_ARM: begin
        // arm is held as a level long enough for the endpoint's synchronizer to see it
        if (ack_sel_c) begin
          ep_arm_d = '0;
          timer_d  = '0;
          state_d  = ST_ARB_ACKWAIT;
        end else if (timer_q == TMR_MAX) begin
          ep_arm_d = '0;
          err_d    = 1'b1;
          state_d  = ST_ARB_RELEASE;
        end
      end
      ST_ARB_ACKWAIT: begin
        if (!ack_sel_c) begin
          state_d = ST_ARB_RELEASE;
        end else if (timer_q == TMR_MAX) begin
          err_d   = 1'b1;
          state_d = ST_ARB_RELEASE;
        end
      end
      ST_ARB_RELEASE: begin
        rr_d    = rr_next_c;
        state_d = ST_ARB_IDLE;
      end
      default: state_d = ST_ARB_IDLE;
    endcase
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      state_q      <= ST_ARB_IDLE;
      prot_ep_q    <= '0;
      gnt_q        <= '0;
      prot_valid_q <= 1'b0;
      ep_arm_q     <= '0;
      err_q        <= 1'b0;
      rr_q         <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      prot_ep_q    <= prot_ep_d;
      gnt_q        <= gnt_d;
      prot_valid_q <= prot_valid_d;
      ep_arm_q     <= ep_arm_d;
      err_q        <= err_d;
      rr_q         <= rr_d;
      timer_q      <= timer_d;
    end
  end

  assign ep_addr     = prot_addr;
  assign ep_arm      = ep_arm_q;
  assign prot_q      = sel_rd_c.q;
  assign prot_len    = sel_rd_c.len;
  assign prot_valid  = prot_valid_q;
  assign prot_ep     = prot_ep_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_usb3_ep_out_arb.sv
// Directed bench for usb3_ep_out_arb with a simple endpoint arm/ack model.
module tb_usb3_ep_out_arb;

  localparam int unsigned NUM_EP = 3;

  logic                  local_clk = 1'b0;
  logic                  reset;
  logic [NUM_EP-1:0]     ep_hasdata;
  logic [NUM_EP*11-1:0]  ep_len;
  logic [NUM_EP*32-1:0]  ep_q;
  logic [8:0]            ep_addr;
  logic [NUM_EP-1:0]     ep_arm;
  logic [NUM_EP-1:0]     ep_arm_ack;
  logic [8:0]            prot_addr;
  logic [31:0]           prot_q;
  logic [10:0]           prot_len;
  logic                  prot_valid;
  logic [2:0]            prot_ep;
  logic                  prot_done;
  logic                  prot_abort;
  logic                  err_timeout;

  always #5 local_clk = ~local_clk;

  usb3_ep_out_arb #(.NUM_EP(NUM_EP), .ACK_TIMEOUT(255)) dut (
    .local_clk   (local_clk),
    .reset       (reset),
    .ep_hasdata  (ep_hasdata),
    .ep_len      (ep_len),
    .ep_q        (ep_q),
    .ep_addr     (ep_addr),
    .ep_arm      (ep_arm),
    .ep_arm_ack  (ep_arm_ack),
    .prot_addr   (prot_addr),
    .prot_q      (prot_q),
    .prot_len    (prot_len),
    .prot_valid  (prot_valid),
    .prot_ep     (prot_ep),
    .prot_done   (prot_done),
    .prot_abort  (prot_abort),
    .err_timeout (err_timeout)
  );

  int errors = 0;
  int checks = 0;
  logic ack_en;

  // Endpoint model: 2-flop sync + edge detect on arm, then ack high for 4 cycles
  logic [NUM_EP-1:0] s1, s2, s3;
  int unsigned ack_cnt [NUM_EP];

  always @(posedge local_clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      for (int i = 0; i < NUM_EP; i++) ack_cnt[i] <= 0;
    end else begin
      s1 <= ep_arm;
      s2 <= s1;
      s3 <= s2;
      for (int i = 0; i < NUM_EP; i++) begin
        if (ack_en && s2[i] && !s3[i]) ack_cnt[i] <= 4;
        else if (ack_cnt[i] != 0)      ack_cnt[i] <= ack_cnt[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_EP; i++) begin
      ep_arm_ack[i]       = (ack_cnt[i] != 0);
      ep_q[i*32 +: 32]    = {16'(16'hBE00 + i), 7'd0, ep_addr};
    end
  end

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] exp_q;
  } dvec_t;

  dvec_t dtab [5];
  int    order [6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge local_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int exp_ep, input string name);
    int n;
    n = 0;
    while (prot_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk({name, "_valid"}, 32'(prot_valid), 32'd1);
    chk({name, "_ep"}, 32'(prot_ep), 32'(exp_ep));
  endtask

  task automatic pulse(input logic d, input logic a);
    prot_done  = d;
    prot_abort = a;
    tick(1);
    prot_done  = 1'b0;
    prot_abort = 1'b0;
  endtask

  // Counts cycles ep_arm stays high, then lets the arbiter get back to IDLE
  task automatic finish_hs(output int n);
    int m;
    n = 0;
    while (ep_arm != '0 && n < 400) begin
      tick(1);
      n++;
    end
    m = 0;
    while (ep_arm_ack != '0 && m < 20) begin
      tick(1);
      m++;
    end
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    ep_hasdata = '0;
    ep_len     = {11'd64, 11'd512, 11'd8};
    prot_addr  = '0;
    prot_done  = 1'b0;
    prot_abort = 1'b0;
    ack_en     = 1'b1;

    dtab[0] = '{addr: 9'd0,   exp_q: 32'hBE01_0000};
    dtab[1] = '{addr: 9'd1,   exp_q: 32'hBE01_0001};
    dtab[2] = '{addr: 9'd2,   exp_q: 32'hBE01_0002};
    dtab[3] = '{addr: 9'd3,   exp_q: 32'hBE01_0003};
    dtab[4] = '{addr: 9'h1FF, exp_q: 32'hBE01_01FF};
`ifdef USB3_EP_ARB_EP0_PRIO_EN
    order = '{0, 1, 0, 2, 0, 1};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif

    tick(3);
    reset = 1'b0;

    chk("rst_arm",   32'(ep_arm),      32'd0);
    chk("rst_valid", 32'(prot_valid),  32'd0);
    chk("rst_ep",    32'(prot_ep),     32'd0);
    chk("rst_err",   32'(err_timeout), 32'd0);
    chk("rst_q",     prot_q,           32'd0);
    chk("rst_len",   32'(prot_len),    32'd0);

    // done/abort outside GRANT
    pulse(1'b1, 1'b1);
    tick(1);
    chk("stray_arm",   32'(ep_arm),     32'd0);
    chk("stray_valid", 32'(prot_valid), 32'd0);

    // single request on ep1: one cycle of grant latency before prot_valid
    ep_hasdata = 3'b010;
    tick(1);
    chk("lat_valid0", 32'(prot_valid), 32'd0);
    tick(1);
    chk("single_valid", 32'(prot_valid), 32'd1);
    chk("single_ep",    32'(prot_ep),    32'd1);
    chk("single_len",   32'(prot_len),   32'd512);
    for (int k = 0; k < 5; k++) begin
      prot_addr = dtab[k].addr;
      #1;
      chk("data_addr", 32'(ep_addr), 32'(dtab[k].addr));
      chk("data_q",    prot_q,       dtab[k].exp_q);
    end

    // hasdata falling during GRANT does not drop the grant
    ep_hasdata = 3'b000;
    tick(2);
    chk("hold_valid", 32'(prot_valid), 32'd1);
    chk("hold_ep",    32'(prot_ep),    32'd1);

    pulse(1'b1, 1'b0);
    chk("done_arm",   32'(ep_arm),     32'b010);
    chk("done_valid", 32'(prot_valid), 32'd0);
    finish_hs(n);
    chk("hs_arm_cycles", 32'(n),           32'd4);
    chk("hs_valid",      32'(prot_valid),  32'd0);
    chk("hs_err",        32'(err_timeout), 32'd0);

    // pointer now at 2: ep2 beats ep1
    ep_hasdata = 3'b110;
    wait_valid(2, "rr2");
    ep_hasdata = 3'b101;
    pulse(1'b0, 1'b1);
    chk("abort_arm",   32'(ep_arm),     32'd0);
    chk("abort_valid", 32'(prot_valid), 32'd0);
    wait_valid(0, "abort_ep0");

    // simultaneous done and abort: done wins
    pulse(1'b1, 1'b1);
    chk("both_arm", 32'(ep_arm), 32'b001);
    ep_hasdata = 3'b100;
    finish_hs(n);
    chk("both_arm_cycles", 32'(n), 32'd4);
    wait_valid(2, "ep2");
    pulse(1'b0, 1'b1);
    chk("abort2_arm", 32'(ep_arm), 32'd0);
    wait_valid(2, "abort_regrant");

    // fairness from a fresh pointer
    do_reset();
    ep_hasdata = 3'b111;
    for (int g = 0; g < 6; g++) begin
      wait_valid(order[g], "fair");
      pulse(1'b1, 1'b0);
`ifdef USB3_EP_ARB_EP0_PRIO_EN
      ep_hasdata[0] = (order[g] != 0);
`endif
      finish_hs(n);
      chk("fair_arm_cycles", 32'(n), 32'd4);
    end

    // ack never arrives: arm held for ACK_TIMEOUT+1 cycles, sticky error
    do_reset();
    ack_en     = 1'b0;
    ep_hasdata = 3'b010;
    wait_valid(1, "to");
    pulse(1'b1, 1'b0);
    chk("to_arm", 32'(ep_arm), 32'b010);
    finish_hs(n);
    chk("to_arm_cycles", 32'(n),           32'd256);
    chk("to_err",        32'(err_timeout), 32'd1);
    ack_en = 1'b1;
    wait_valid(1, "to_regrant");
    chk("to_err_sticky", 32'(err_timeout), 32'd1);

    // reset while ep0 is armed
    ack_en     = 1'b0;
    ep_hasdata = 3'b001;
    pulse(1'b0, 1'b1);
    wait_valid(0, "rarm");
    pulse(1'b1, 1'b0);
    tick(3);
    chk("rarm_arm", 32'(ep_arm), 32'b001);
    reset = 1'b1;
    tick(1);
    chk("rarm_arm_clr", 32'(ep_arm),      32'd0);
    chk("rarm_valid",   32'(prot_valid),  32'd0);
    chk("rarm_err",     32'(err_timeout), 32'd0);
    reset      = 1'b0;
    ack_en     = 1'b1;
    ep_hasdata = 3'b110;
    wait_valid(1, "rarm_rr0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
